// File: rtl/botloc_pkg.sv
// Shared types and constants for the bot location frame controller.
package botloc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StCommit  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_LOCX = 2'd0;
  localparam logic [1:0] SEL_LOCY = 2'd1;
  localparam logic [1:0] SEL_INFO = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam logic [7:0] OVR_MAX = 8'd255;

endpackage

// File: rtl/botloc_rr_arb2.sv
// Two-requester round-robin arbiter. Requester a is the simulator, b the CPU.
module botloc_rr_arb2
  import botloc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // 0: a favoured on contention, 1: b favoured
  logic ptr_q, ptr_d;

  // Grant decode; on contention the pointer moves to the loser.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    ptr_d = ptr_q;
    if (req_a && req_b) begin
      gnt_a = ~ptr_q;
      gnt_b = ptr_q;
      ptr_d = ~ptr_q;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/botloc_frame_ctrl.sv
// Bot location/info register owner: shadow set shared by simulator and CPU,
// committed to the display-side registers at vertical-blank start.
// Optional overrun counter enabled by defining BOTLOC_OVERRUN_CNT_EN.
module botloc_frame_ctrl
  import botloc_pkg::*;
#(
  parameter int unsigned LOC_W  = 8,
  parameter int unsigned INFO_W = 8,
  parameter int unsigned MAX_X  = 127,
  parameter int unsigned MAX_Y  = 127
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              sim_upd,
  input  logic [LOC_W-1:0]  sim_locx,
  input  logic [LOC_W-1:0]  sim_locy,
  input  logic [INFO_W-1:0] sim_info,
  input  logic              cpu_wr_req,
  input  logic [1:0]        cpu_wr_sel,
  input  logic [7:0]        cpu_wr_data,
  output logic              cpu_wr_ack,
  output logic [LOC_W-1:0]  LocX_reg,
  output logic [LOC_W-1:0]  LocY_reg,
  output logic [INFO_W-1:0] BotInfo_reg,
  output logic              commit_pulse,
  output logic              pending,
  output logic [7:0]        overrun_cnt
);

  localparam logic [LOC_W-1:0] MAX_X_LIM = LOC_W'(MAX_X);
  localparam logic [LOC_W-1:0] MAX_Y_LIM = LOC_W'(MAX_Y);

  function automatic logic [LOC_W-1:0] clamp(input logic [LOC_W-1:0] v,
                                             input logic [LOC_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_e              state_q, state_d;
  logic                vblank_q, vb_rise;
  logic                dirty_q, dirty_d;
  logic                ack_q;
  logic                hold_vld_q, hold_load;
  logic [LOC_W-1:0]    hold_x_q, hold_y_q;
  logic [INFO_W-1:0]   hold_info_q;
  logic [LOC_W-1:0]    shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic [INFO_W-1:0]   shd_info_q, shd_info_d;
  logic [LOC_W-1:0]    locx_q, locy_q;
  logic [INFO_W-1:0]   info_q;
  logic                commit_pulse_q;
  logic                commit_en, shadow_we;
  logic                arb_req_sim, arb_req_cpu, gnt_sim, gnt_cpu, sim_take;
  logic [LOC_W-1:0]    src_x, src_y, cpu_loc;
  logic [INFO_W-1:0]   src_info, cpu_info;

  assign vb_rise = vblank & ~vblank_q;

  // A held sim update replays with top priority, so the arbiter sits out that cycle.
  // The CPU request is masked during its ack cycle since req is still high then.
  assign arb_req_sim = sim_upd & ~hold_vld_q;
  assign arb_req_cpu = cpu_wr_req & ~ack_q & ~hold_vld_q;

  botloc_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (arb_req_sim),
    .req_b   (arb_req_cpu),
    .gnt_a   (gnt_sim),
    .gnt_b   (gnt_cpu)
  );

  assign sim_take  = hold_vld_q | gnt_sim;
  // New pulse not serviced this cycle (lost arbitration or blocked by replay) is parked.
  assign hold_load = sim_upd & (hold_vld_q | ~gnt_sim);

  assign src_x    = hold_vld_q ? hold_x_q    : sim_locx;
  assign src_y    = hold_vld_q ? hold_y_q    : sim_locy;
  assign src_info = hold_vld_q ? hold_info_q : sim_info;
  assign cpu_loc  = LOC_W'(cpu_wr_data);
  assign cpu_info = INFO_W'(cpu_wr_data);

  // Shadow next-state from whichever requester was granted.
  always_comb begin
    shd_x_d    = shd_x_q;
    shd_y_d    = shd_y_q;
    shd_info_d = shd_info_q;
    shadow_we  = 1'b0;
    if (sim_take) begin
      shd_x_d    = clamp(src_x, MAX_X_LIM);
      shd_y_d    = clamp(src_y, MAX_Y_LIM);
      shd_info_d = src_info;
      shadow_we  = 1'b1;
    end else if (gnt_cpu) begin
      unique case (cpu_wr_sel)
        SEL_LOCX: begin
          shd_x_d   = clamp(cpu_loc, MAX_X_LIM);
          shadow_we = 1'b1;
        end
        SEL_LOCY: begin
          shd_y_d   = clamp(cpu_loc, MAX_Y_LIM);
          shadow_we = 1'b1;
        end
        SEL_INFO: begin
          shd_info_d = cpu_info;
          shadow_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM: wait for dirty data, then for vblank rise, then copy for one cycle.
  always_comb begin
    state_d   = state_q;
    dirty_d   = dirty_q | shadow_we;
    commit_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dirty_q) state_d = StPending;
      end
      StPending: begin
        if (vb_rise) state_d = StCommit;
      end
      StCommit: begin
        commit_en = 1'b1;
        // A write landing in the commit cycle stays dirty for the next frame.
        dirty_d   = shadow_we;
        state_d   = shadow_we ? StPending : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, shadow, hold, handshake and display-side registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      vblank_q       <= 1'b0;
      dirty_q        <= 1'b0;
      ack_q          <= 1'b0;
      hold_vld_q     <= 1'b0;
      hold_x_q       <= '0;
      hold_y_q       <= '0;
      hold_info_q    <= '0;
      shd_x_q        <= '0;
      shd_y_q        <= '0;
      shd_info_q     <= '0;
      locx_q         <= '0;
      locy_q         <= '0;
      info_q         <= '0;
      commit_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vblank_q       <= vblank;
      dirty_q        <= dirty_d;
      ack_q          <= gnt_cpu;
      hold_vld_q     <= hold_load;
      if (hold_load) begin
        hold_x_q    <= sim_locx;
        hold_y_q    <= sim_locy;
        hold_info_q <= sim_info;
      end
      shd_x_q        <= shd_x_d;
      shd_y_q        <= shd_y_d;
      shd_info_q     <= shd_info_d;
      // Copy the pre-write shadow so a same-cycle write lands in the next frame.
      if (commit_en) begin
        locx_q <= shd_x_q;
        locy_q <= shd_y_q;
        info_q <= shd_info_q;
      end
      commit_pulse_q <= commit_en;
    end
  end

`ifdef BOTLOC_OVERRUN_CNT_EN
  logic [7:0] ovr_q;

  // Count writes that overwrite uncommitted data; commit-cycle writes are not overruns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= '0;
    end else if (shadow_we && dirty_q && (state_q != StCommit) && (ovr_q != OVR_MAX)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

  assign cpu_wr_ack   = ack_q;
  assign LocX_reg     = locx_q;
  assign LocY_reg     = locy_q;
  assign BotInfo_reg  = info_q;
  assign commit_pulse = commit_pulse_q;
  assign pending      = (state_q != StIdle);

endmodule

// File: tb/tb_botloc_frame_ctrl.sv
// Self-checking bench for botloc_frame_ctrl against a field-level reference model.
module tb_botloc_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vblank = 1'b0;
  logic       sim_upd = 1'b0;
  logic [7:0] sim_locx = '0, sim_locy = '0, sim_info = '0;
  logic       cpu_wr_req = 1'b0;
  logic [1:0] cpu_wr_sel = '0;
  logic [7:0] cpu_wr_data = '0;
  logic       cpu_wr_ack;
  logic [7:0] LocX_reg, LocY_reg, BotInfo_reg;
  logic       commit_pulse, pending;
  logic [7:0] overrun_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: shadow fields, committed fields, dirty flag, overrun count.
  logic [7:0] m_x, m_y, m_i, c_x, c_y, c_i;
  bit         m_dirty;
  int         m_ovr;
  bit         exp_pulse;

  botloc_frame_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vblank       (vblank),
    .sim_upd      (sim_upd),
    .sim_locx     (sim_locx),
    .sim_locy     (sim_locy),
    .sim_info     (sim_info),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_sel   (cpu_wr_sel),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ack   (cpu_wr_ack),
    .LocX_reg     (LocX_reg),
    .LocY_reg     (LocY_reg),
    .BotInfo_reg  (BotInfo_reg),
    .commit_pulse (commit_pulse),
    .pending      (pending),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] clampv(input logic [7:0] v);
    return (v > 8'd127) ? 8'd127 : v;
  endfunction

  function automatic logic [7:0] exp_ovr();
`ifdef BOTLOC_OVERRUN_CNT_EN
    return 8'(m_ovr);
`else
    return 8'd0;
`endif
  endfunction

  function automatic void m_reset();
    m_x = 0; m_y = 0; m_i = 0; c_x = 0; c_y = 0; c_i = 0;
    m_dirty = 0; m_ovr = 0;
  endfunction

  function automatic void m_write_mark();
    if (m_dirty && m_ovr < 255) m_ovr++;
    m_dirty = 1;
  endfunction

  function automatic void m_sim(input logic [7:0] x, input logic [7:0] y, input logic [7:0] i);
    m_write_mark();
    m_x = clampv(x); m_y = clampv(y); m_i = i;
  endfunction

  function automatic void m_cpu(input logic [1:0] sel, input logic [7:0] d);
    if (sel == 2'd3) return;
    m_write_mark();
    case (sel)
      2'd0:    m_x = clampv(d);
      2'd1:    m_y = clampv(d);
      default: m_i = d;
    endcase
  endfunction

  function automatic void m_commit();
    exp_pulse = m_dirty;
    if (m_dirty) begin
      c_x = m_x; c_y = m_y; c_i = m_i;
      m_dirty = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sim_upd = 0; cpu_wr_req = 0; vblank = 0;
    reset_n = 0;
    #7;
    @(negedge clk);
    reset_n = 1;
    m_reset();
    tick();
  endtask

  task automatic sim_write(input logic [7:0] x, input logic [7:0] y, input logic [7:0] i);
    sim_upd = 1; sim_locx = x; sim_locy = y; sim_info = i;
    tick();
    sim_upd = 0;
    m_sim(x, y, i);
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] d);
    bit acked = 0;
    cpu_wr_req = 1; cpu_wr_sel = sel; cpu_wr_data = d;
    for (int k = 0; k < 8 && !acked; k++) begin
      tick();
      if (cpu_wr_ack) acked = 1;
    end
    cpu_wr_req = 0;
    if (!acked) begin
      checks++; errors++;
      $display("FAIL cpu_ack_timeout: got no ack within 8 cycles, required an ack");
    end
    m_cpu(sel, d);
  endtask

  // Ends two edges after the vblank rise, with vblank left high.
  task automatic commit_frame();
    vblank = 0;
    tick(); tick();
    vblank = 1;
    tick(); tick();
    m_commit();
  endtask

  task automatic test_reset();
    reset_n = 0;
    #13;
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0", {LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt});
    end
    checks++;
    if ({cpu_wr_ack, commit_pulse, pending} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {cpu_wr_ack, commit_pulse, pending});
    end
    @(negedge clk);
    reset_n = 1;
    m_reset();
    tick(); tick();
    checks++;
    if ({pending, commit_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got %b want 00", {pending, commit_pulse});
    end
  endtask

  task automatic test_single();
    sim_write(8'd10, 8'd20, 8'd3);
    tick();
    checks++;
    if (pending !== 1'b1) begin
      errors++; $display("FAIL single_pending: got %b want 1", pending);
    end
    vblank = 1;
    tick();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg} !== 24'h0) begin
      errors++;
      $display("FAIL single_edge1: got %h want 000000", {LocX_reg, LocY_reg, BotInfo_reg});
    end
    tick();
    m_commit();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, commit_pulse, pending} !== {8'd10, 8'd20, 8'd3, 2'b10}) begin
      errors++;
      $display("FAIL single_commit: got %0d/%0d/%0d p=%b pend=%b want 10/20/3 p=1 pend=0",
               LocX_reg, LocY_reg, BotInfo_reg, commit_pulse, pending);
    end
    tick();
    checks++;
    if (commit_pulse !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: got %b want 0", commit_pulse);
    end
    vblank = 0;
    tick();
  endtask

  task automatic test_clamp();
    logic [7:0] inf = 8'($urandom);
    sim_write(8'd200, 8'd255, inf);
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg} !== {8'd127, 8'd127, inf}) begin
      errors++;
      $display("FAIL clamp_sim: got %0d/%0d/%0d want 127/127/%0d", LocX_reg, LocY_reg,
               BotInfo_reg, inf);
    end
    cpu_write(2'd0, 8'd150);
    cpu_write(2'd1, 8'd126);
    cpu_write(2'd2, 8'd200);
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg} !== {c_x, c_y, c_i}) begin
      errors++;
      $display("FAIL clamp_cpu: got %0d/%0d/%0d want %0d/%0d/%0d", LocX_reg, LocY_reg,
               BotInfo_reg, c_x, c_y, c_i);
    end
  endtask

  task automatic test_contention();
    logic [7:0] x1 = 8'($urandom), y1 = 8'($urandom), i1 = 8'($urandom), d1 = 8'($urandom);
    logic [7:0] x2 = 8'($urandom), y2 = 8'($urandom), i2 = 8'($urandom), d2 = 8'($urandom);
    do_reset();
    sim_upd = 1; sim_locx = x1; sim_locy = y1; sim_info = i1;
    cpu_wr_req = 1; cpu_wr_sel = 2'd1; cpu_wr_data = d1;
    tick();
    sim_upd = 0;
    m_sim(x1, y1, i1);
    checks++;
    if (cpu_wr_ack !== 1'b0) begin
      errors++; $display("FAIL contend1_sim_first: ack got %b want 0", cpu_wr_ack);
    end
    tick();
    checks++;
    if (cpu_wr_ack !== 1'b1) begin
      errors++; $display("FAIL contend1_cpu_next: ack got %b want 1", cpu_wr_ack);
    end
    cpu_wr_req = 0;
    m_cpu(2'd1, d1);
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt} !== {c_x, c_y, c_i, exp_ovr()}) begin
      errors++;
      $display("FAIL contend1_commit: got %0d/%0d/%0d ovr=%0d want %0d/%0d/%0d ovr=%0d",
               LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt, c_x, c_y, c_i, exp_ovr());
    end
    sim_upd = 1; sim_locx = x2; sim_locy = y2; sim_info = i2;
    cpu_wr_req = 1; cpu_wr_sel = 2'd0; cpu_wr_data = d2;
    tick();
    sim_upd = 0;
    checks++;
    if (cpu_wr_ack !== 1'b1) begin
      errors++; $display("FAIL contend2_cpu_first: ack got %b want 1", cpu_wr_ack);
    end
    cpu_wr_req = 0;
    m_cpu(2'd0, d2);
    tick();
    m_sim(x2, y2, i2);
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt} !== {c_x, c_y, c_i, exp_ovr()}) begin
      errors++;
      $display("FAIL contend2_commit: got %0d/%0d/%0d ovr=%0d want %0d/%0d/%0d ovr=%0d",
               LocX_reg, LocY_reg, BotInfo_reg, overrun_cnt, c_x, c_y, c_i, exp_ovr());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    sim_write(8'd1, 8'd5, 8'd7);
    sim_write(8'd2, 8'd5, 8'd7);
    sim_write(8'd3, 8'd5, 8'd7);
    commit_frame();
    checks++;
    if ({LocX_reg, overrun_cnt} !== {8'd3, exp_ovr()}) begin
      errors++;
      $display("FAIL overrun: got x=%0d ovr=%0d want x=3 ovr=%0d", LocX_reg, overrun_cnt,
               exp_ovr());
    end
  endtask

  task automatic test_commit_cycle_write();
    logic [7:0] a = 8'($urandom_range(0, 127)), b = 8'($urandom_range(0, 127));
    logic [7:0] ovr_before;
    sim_write(a, a, a);
    vblank = 0;
    tick(); tick();
    vblank = 1;
    tick();
    ovr_before = exp_ovr();
    m_commit();
    sim_write(b, b, b);
    checks++;
    if ({LocX_reg, pending, commit_pulse} !== {a, 2'b11}) begin
      errors++;
      $display("FAIL commit_write_old: got x=%0d pend=%b p=%b want x=%0d pend=1 p=1",
               LocX_reg, pending, commit_pulse, a);
    end
    checks++;
    if (overrun_cnt !== ovr_before) begin
      errors++;
      $display("FAIL commit_write_no_ovr: got %0d want %0d", overrun_cnt, ovr_before);
    end
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg} !== {b, b, b}) begin
      errors++;
      $display("FAIL commit_write_next: got %0d/%0d/%0d want %0d", LocX_reg, LocY_reg,
               BotInfo_reg, b);
    end
  endtask

  task automatic test_vblank_held();
    int pulses = 0;
    logic [7:0] b = 8'($urandom_range(0, 100));
    sim_write(8'd50, 8'd60, 8'd70);
    commit_frame();
    for (int k = 0; k < 50; k++) begin
      if (k == 10) sim_write(b, b, b);
      else tick();
      if (commit_pulse) pulses++;
    end
    checks++;
    if ({pulses[7:0], LocX_reg, pending} !== {8'd0, 8'd50, 1'b1}) begin
      errors++;
      $display("FAIL vblank_held: got pulses=%0d x=%0d pend=%b want 0/50/1", pulses,
               LocX_reg, pending);
    end
    commit_frame();
    checks++;
    if ({LocX_reg, commit_pulse} !== {b, 1'b1}) begin
      errors++;
      $display("FAIL vblank_next_frame: got x=%0d p=%b want x=%0d p=1", LocX_reg,
               commit_pulse, b);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [7:0] v3 = 8'($urandom_range(1, 127));
    sim_write(8'd11, 8'd22, 8'd33);
    commit_frame();
    sim_write(8'd44, 8'd55, 8'd66);
    tick(); tick();
    #2 reset_n = 0;
    #1;
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, pending} !== 25'h0) begin
      errors++;
      $display("FAIL reset_pending: got %0d/%0d/%0d pend=%b want 0", LocX_reg, LocY_reg,
               BotInfo_reg, pending);
    end
    @(negedge clk);
    reset_n = 1;
    m_reset();
    sim_write(8'd11, 8'd22, 8'd33);
    commit_frame();
    sim_write(8'd44, 8'd55, 8'd66);
    vblank = 0;
    tick(); tick();
    vblank = 1;
    tick();
    #2 reset_n = 0;
    #1;
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg, pending} !== 25'h0) begin
      errors++;
      $display("FAIL reset_commit: got %0d/%0d/%0d pend=%b want 0", LocX_reg, LocY_reg,
               BotInfo_reg, pending);
    end
    @(negedge clk);
    reset_n = 1;
    m_reset();
    sim_write(v3, v3, v3);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (commit_pulse) pulses++;
    end
    checks++;
    if ({pulses[7:0], LocX_reg, pending} !== {8'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_no_commit: got pulses=%0d x=%0d pend=%b want 0/0/1", pulses,
               LocX_reg, pending);
    end
    commit_frame();
    checks++;
    if ({LocX_reg, LocY_reg, BotInfo_reg} !== {v3, v3, v3}) begin
      errors++;
      $display("FAIL reset_fresh_rise: got %0d/%0d/%0d want %0d", LocX_reg, LocY_reg,
               BotInfo_reg, v3);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      int n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) begin
        if ($urandom_range(0, 1) == 0)
          sim_write(8'($urandom), 8'($urandom), 8'($urandom));
        else
          cpu_write(2'($urandom_range(0, 3)), 8'($urandom));
      end
      commit_frame();
      checks++;
      if ({LocX_reg, LocY_reg, BotInfo_reg, commit_pulse, pending, overrun_cnt} !==
          {c_x, c_y, c_i, exp_pulse, 1'b0, exp_ovr()}) begin
        errors++;
        $display("FAIL random_%0d: got %0d/%0d/%0d p=%b pend=%b ovr=%0d want %0d/%0d/%0d p=%b pend=0 ovr=%0d",
                 it, LocX_reg, LocY_reg, BotInfo_reg, commit_pulse, pending, overrun_cnt,
                 c_x, c_y, c_i, exp_pulse, exp_ovr());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_clamp();
    test_contention();
    test_overrun();
    test_commit_cycle_write();
    test_vblank_held();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/botloc_frame_ctrl.md
Name: botloc_frame_ctrl

Overview:
- Owns the bot location/info registers (LocX_reg, LocY_reg, BotInfo_reg) that drive the icon overlay logic.
- Two requesters share one shadow register set:
  - the bot simulator (bulk update pulse);
  - the CPU (single-register writes with req/ack).
- Commits the shadow set to the display-side registers once per frame, at vertical-blank start, so the icon never tears mid-frame.
- Round-robin arbitration between the two requesters; coordinate clamping; overrun detection.

Parameters:
- LOC_W, 8, width of X/Y location fields
- INFO_W, 8, width of BotInfo field
- MAX_X, 127, largest legal X (icon grid column)
- MAX_Y, 127, largest legal Y (icon grid row)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vblank  in  1  level, high during vertical blanking; synchronous to clk
- sim_upd  in  1  one-cycle pulse: sim_locx/sim_locy/sim_info valid
- sim_locx  in  LOC_W  simulator X
- sim_locy  in  LOC_W  simulator Y
- sim_info  in  INFO_W  simulator BotInfo
- cpu_wr_req  in  1  CPU write request; held high until acked
- cpu_wr_sel  in  2  0=LocX, 1=LocY, 2=BotInfo, 3=reserved
- cpu_wr_data  in  8  CPU write data
- cpu_wr_ack  out  1  one-cycle grant/complete pulse
- LocX_reg  out  LOC_W  committed X
- LocY_reg  out  LOC_W  committed Y
- BotInfo_reg  out  INFO_W  committed BotInfo
- commit_pulse  out  1  high for the one cycle after a commit
- pending  out  1  shadow holds uncommitted data
- overrun_cnt  out  8  saturating count of updates that overwrote uncommitted data

Behaviour:
- Reset (async assert, sync deassert in use): all outputs 0; shadow 0; FSM IDLE; vblank_q=0; rr pointer favours sim.
- Edge detect: vblank_q registered each cycle; vb_rise = vblank & ~vblank_q.
- Arbitration, each cycle:
  - Only sim_upd: sim wins. Only cpu_wr_req: CPU wins.
  - Both: winner = rr pointer; pointer toggles to the loser after every contested grant.
  - A losing sim_upd is held in a one-entry sim_hold register and replayed next cycle at top priority (never lost).
  - A losing CPU simply waits (req stays high).
- Sim grant: shadow X = min(sim_locx, MAX_X), Y = min(sim_locy, MAX_Y), info = sim_info.
- CPU grant:
  - Updates the selected shadow field only; X/Y clamped the same way; data zero-extended/truncated to the field width.
  - cpu_wr_ack is high the cycle after the grant.
  - sel=3: no shadow change, but ack still given; no dirty set.
- Shadow write, dirty rule: if dirty was already 1 and not cleared this cycle, overrun_cnt += 1, saturating at 255. Then dirty=1.
- FSM:
  - IDLE: dirty → PENDING.
  - PENDING: vb_rise → COMMIT.
  - COMMIT (one cycle): outputs <= shadow; dirty cleared, unless a shadow write lands this same cycle; commit_pulse next cycle. Then dirty ? PENDING : IDLE.
- pending = (state != IDLE).
- Latency: outputs change on the second clk edge after vblank is first sampled high (edge 1 detect → COMMIT, edge 2 copy).
- Write during COMMIT: the committed value is the pre-write shadow. The write stays dirty for next frame; this is not an overrun.
- vblank held high: only one commit per rising edge. A write arriving later in the same blanking waits for the next frame.
- vblank already high at reset release: no commit until it falls and rises again.
- Reset mid-COMMIT: outputs return to 0 immediately; pending data discarded.

Optional Feature:
- Macro: BOTLOC_OVERRUN_CNT_EN.
- Defined: overrun_cnt counts as above.
- Undefined:
  - counter logic removed; overrun_cnt tied to 0;
  - all other behaviour identical.

Decomposition:
- Package botloc_pkg:
  - FSM state enum (IDLE, PENDING, COMMIT);
  - cpu_wr_sel codes SEL_LOCX/SEL_LOCY/SEL_INFO/SEL_RSVD;
  - OVR_MAX=255.
- Sub-module botloc_rr_arb2: two-requester round-robin arbiter with pointer register and grant outputs.

Test Plan:
- Single update: sim_upd X=10,Y=20,info=3 while vblank=0; raise vblank → outputs 10/20/3 on the 2nd edge; commit_pulse one cycle; pending falls.
- Clamp: sim_locx=200, sim_locy=255 → committed X=127, Y=127. CPU sel=0 data=150 → X=127.
- Contention: sim_upd and cpu_wr_req in the same cycle after reset → sim first; CPU ack the next cycle; repeat contention → CPU first (pointer toggled). Both updates visible after one commit.
- Overrun: three sim updates (X=1, 2, 3) before vblank → commit X=3; overrun_cnt=2. With the macro off → 0.
- Timing:
  - Write in the COMMIT cycle → old value committed; pending stays 1; new value appears at the next vblank rise.
  - vblank held high 50 cycles with writes → no second commit.
- Reset: assert reset_n low during PENDING and again during COMMIT → outputs 0 asynchronously; no commit after release until a fresh vblank rise.
